br_flow_pack: RTL and testbench

// - Downstream pop-side stage for br_fifo variants: consumes narrow beats from a FIFO pop

---
 rtl/br_flow_pack_out_reg.sv | 70 +++++++
 rtl/br_flow_pack.sv | 106 ++++++++++
 tb/tb_br_flow_pack.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/br_flow_pack_out_reg.sv
// ---------------------------------------------------------------------------
// br_flow_pack_out_reg
// Purpose : valid/ready output register for the beat packer. Holds one packed
//           word together with its beat count and last flag, and presents it
//           downstream until the consumer takes it.
// Ports   :
//   clk            in   clock, all state on rising edge
//   rst_n          in   asynchronous reset, active-low
//   load_valid_i   in   a completed word is offered this cycle
//   load_data_i    in   completed word payload
//   load_beats_i   in   number of valid beats in load_data_i
//   load_last_i    in   word was closed by push_last
//   pop_ready_i    in   consumer accepts the held word
//   pop_valid_o    out  held word valid
//   pop_data_o     out  held word payload
//   pop_beats_o    out  held word beat count
//   pop_last_o     out  held word last flag
// ---------------------------------------------------------------------------
module br_flow_pack_out_reg #(
    parameter int Width      = 8,
    parameter int NumBeats   = 4,
    parameter int CountWidth = $clog2(NumBeats + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_valid_i,
    input  logic [NumBeats*Width-1:0] load_data_i,
    input  logic [CountWidth-1:0]     load_beats_i,
    input  logic                      load_last_i,
    input  logic                      pop_ready_i,
    output logic                      pop_valid_o,
    output logic [NumBeats*Width-1:0] pop_data_o,
    output logic [CountWidth-1:0]     pop_beats_o,
    output logic                      pop_last_o
);

    logic                      valid_q;
    logic [NumBeats*Width-1:0] data_q;
    logic [CountWidth-1:0]     beats_q;
    logic                      last_q;
    logic                      load_en;

    // The register may take a new word whenever it is empty or its current
    // word is leaving this cycle, so a drain and a reload can share one edge.
    assign load_en = !valid_q || pop_ready_i;

    // Payload only changes when a real word is loaded; a plain drain just
    // drops valid and leaves the old payload parked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            beats_q <= '0;
            last_q  <= 1'b0;
        end else if (load_en) begin
            valid_q <= load_valid_i;
            if (load_valid_i) begin
                data_q  <= load_data_i;
                beats_q <= load_beats_i;
                last_q  <= load_last_i;
            end
        end
    end

    assign pop_valid_o = valid_q;
    assign pop_data_o  = data_q;
    assign pop_beats_o = beats_q;
    assign pop_last_o  = last_q;

endmodule

// File: rtl/br_flow_pack.sv
// ---------------------------------------------------------------------------
// br_flow_pack
// Purpose : packs up to NumBeats narrow beats from a FIFO pop interface into
//           one wide word, emitted on a registered valid/ready interface with
//           a beat count and a last flag.
// Ports   :
//   clk         in   clock, all state on rising edge
//   rst_n       in   asynchronous reset, active-low
//   push_ready  out  stage accepts a beat
//   push_valid  in   beat valid
//   push_data   in   beat payload
//   push_last   in   beat closes the current word early
//   pop_ready   in   consumer accepts the word
//   pop_valid   out  packed word valid
//   pop_data    out  packed word, beat i at [i*Width +: Width]
//   pop_beats   out  number of valid beats in pop_data
//   pop_last    out  word was closed by push_last
// ---------------------------------------------------------------------------
module br_flow_pack #(
    parameter int Width    = 8,
    parameter int NumBeats = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    output logic                                  push_ready,
    input  logic                                  push_valid,
    input  logic [Width-1:0]                      push_data,
    input  logic                                  push_last,
    input  logic                                  pop_ready,
    output logic                                  pop_valid,
    output logic [NumBeats*Width-1:0]             pop_data,
    output logic [$clog2(NumBeats+1)-1:0]         pop_beats,
    output logic                                  pop_last
);

    localparam int CountWidth = $clog2(NumBeats + 1);
    localparam int DataWidth  = NumBeats * Width;

    logic [CountWidth-1:0] count_q, count_d;
    logic [DataWidth-1:0]  acc_q, acc_d;
    logic [DataWidth-1:0]  acc_with_beat;
    logic                  accept;
    logic                  complete;

    // Ready depends only on the output register, never on push_valid, so the
    // upstream FIFO sees no combinational loop through this stage.
    assign push_ready = !pop_valid || pop_ready;
    assign accept     = push_valid && push_ready;
    assign complete   = accept &&
                        ((count_q == CountWidth'(NumBeats - 1)) || push_last);

    // Accumulator image including the incoming beat in slot[count]; this is
    // what gets handed to the output register when the word completes.
    always_comb begin
        acc_with_beat = acc_q;
        for (int i = 0; i < NumBeats; i++) begin
            if (count_q == CountWidth'(i)) begin
                acc_with_beat[i*Width +: Width] = push_data;
            end
        end
    end

    // On completion the accumulator and counter restart in the same edge the
    // word moves out, which lets the next beat land without a bubble.
    always_comb begin
        count_d = count_q;
        acc_d   = acc_q;
        if (complete) begin
            count_d = '0;
            acc_d   = '0;
        end else if (accept) begin
            count_d = count_q + CountWidth'(1);
            acc_d   = acc_with_beat;
        end
    end

    // Partial word state; reset discards any half-built word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            acc_q   <= '0;
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
        end
    end

    br_flow_pack_out_reg #(
        .Width      (Width),
        .NumBeats   (NumBeats),
        .CountWidth (CountWidth)
    ) u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid_i (complete),
        .load_data_i  (acc_with_beat),
        .load_beats_i (count_q + CountWidth'(1)),
        .load_last_i  (push_last),
        .pop_ready_i  (pop_ready),
        .pop_valid_o  (pop_valid),
        .pop_data_o   (pop_data),
        .pop_beats_o  (pop_beats),
        .pop_last_o   (pop_last)
    );

endmodule

// File: tb/tb_br_flow_pack.sv
// ---------------------------------------------------------------------------
// tb_br_flow_pack
// Purpose : self-checking bench for br_flow_pack with Width=8, NumBeats=4.
//           Table of single-word vectors, hand-written multi-cycle sequences
//           and a randomized run against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_br_flow_pack;

    localparam int Width    = 8;
    localparam int NumBeats = 4;
    localparam int CntW     = $clog2(NumBeats + 1);

    logic                      clk;
    logic                      rst_n;
    logic                      push_ready;
    logic                      push_valid;
    logic [Width-1:0]          push_data;
    logic                      push_last;
    logic                      pop_ready;
    logic                      pop_valid;
    logic [NumBeats*Width-1:0] pop_data;
    logic [CntW-1:0]           pop_beats;
    logic                      pop_last;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int                       n;
        logic [NumBeats-1:0][7:0] b;
        logic                     lastOnFinal;
        logic [31:0]              expData;
        int                       expBeats;
        logic                     expLast;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          beats;
        logic        last;
    } word_t;

    vec_t vecs[6];

    br_flow_pack #(
        .Width    (Width),
        .NumBeats (NumBeats)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_ready (push_ready),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_last  (push_last),
        .pop_ready  (pop_ready),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_beats  (pop_beats),
        .pop_last   (pop_last)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, reports a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents one beat right after a rising edge and holds it until the
    // stage accepts it; returns just after the accepting edge.
    task automatic applyStimulus(input logic [7:0] d, input logic last);
        bit taken;
        taken = 1'b0;
        @(posedge clk);
        #1;
        push_valid = 1'b1;
        push_data  = d;
        push_last  = last;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (push_ready) begin
                taken = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
        end
        if (!taken) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: got push_ready=0, expected acceptance within 100 cycles");
        end
        push_valid = 1'b0;
        push_last  = 1'b0;
    endtask

    // Reference model: list of accepted beats, closed into a word at four
    // beats or at a last beat.
    logic [7:0] part[$];
    word_t      expQ[$];

    task automatic modelBeat(input logic [7:0] d, input logic last);
        word_t w;
        part.push_back(d);
        if (part.size() == NumBeats || last) begin
            w.data  = '0;
            w.beats = part.size();
            w.last  = last;
            foreach (part[i]) w.data = w.data | (32'(part[i]) << (8 * i));
            expQ.push_back(w);
            part.delete();
        end
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] words[$];
        int          firstIdx;
        int          secondIdx;
        int          popped;
        bit          stall;
        logic [31:0] sData;
        logic [CntW-1:0] sBeats;
        logic        sLast;
        bit          acc;
        bit          hs;
        logic [7:0]  rd;
        logic        rl;
        word_t       w;

        vecs[0] = '{4, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b0, 32'h44332211, 4, 1'b0};
        vecs[1] = '{1, {8'h00, 8'h00, 8'h00, 8'hAA}, 1'b1, 32'h000000AA, 1, 1'b1};
        vecs[2] = '{4, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b1, 32'h44332211, 4, 1'b1};
        vecs[3] = '{2, {8'h00, 8'h00, 8'hC3, 8'h5A}, 1'b1, 32'h0000C35A, 2, 1'b1};
        vecs[4] = '{3, {8'h00, 8'h03, 8'h02, 8'h01}, 1'b1, 32'h00030201, 3, 1'b1};
        vecs[5] = '{4, {8'hEF, 8'hBE, 8'hAD, 8'hDE}, 1'b0, 32'hEFBEADDE, 4, 1'b0};

        rst_n      = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        push_last  = 1'b0;
        pop_ready  = 1'b1;

        // Reset state.
        #12;
        checkOutput("reset_pop_valid", 64'(pop_valid), 64'd0);
        checkOutput("reset_pop_data", 64'(pop_data), 64'd0);
        checkOutput("reset_pop_beats", 64'(pop_beats), 64'd0);
        checkOutput("reset_pop_last", 64'(pop_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_push_ready", 64'(push_ready), 64'd1);

        // Table vectors: each entry is one word, checked one cycle after its
        // closing beat, then drained.
        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < vecs[v].n; j++) begin
                applyStimulus(vecs[v].b[j], (j == vecs[v].n - 1) ? vecs[v].lastOnFinal : 1'b0);
            end
            @(negedge clk);
            checkOutput($sformatf("vec%0d_valid", v), 64'(pop_valid), 64'd1);
            checkOutput($sformatf("vec%0d_data", v), 64'(pop_data), 64'(vecs[v].expData));
            checkOutput($sformatf("vec%0d_beats", v), 64'(pop_beats), 64'(vecs[v].expBeats));
            checkOutput($sformatf("vec%0d_last", v), 64'(pop_last), 64'(vecs[v].expLast));
        end
        @(negedge clk);
        checkOutput("table_drained", 64'(pop_valid), 64'd0);

        // Backpressure: word pending with pop_ready low for five cycles.
        pop_ready = 1'b0;
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp_valid", 64'(pop_valid), 64'd1);
            checkOutput("bp_data", 64'(pop_data), 64'h44332211);
            checkOutput("bp_push_ready", 64'(push_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        pop_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_push_ready", 64'(push_ready), 64'd1);
        @(negedge clk);
        checkOutput("bp_drained", 64'(pop_valid), 64'd0);

        // Eight back-to-back beats with the consumer always ready.
        firstIdx  = -1;
        secondIdx = -1;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            push_valid = (i < 8);
            push_data  = 8'(i + 1);
            push_last  = 1'b0;
            @(negedge clk);
            if (i < 8) checkOutput($sformatf("b2b_push_ready%0d", i), 64'(push_ready), 64'd1);
            if (pop_valid) begin
                words.push_back(pop_data);
                if (firstIdx < 0) firstIdx = i;
                else if (secondIdx < 0) secondIdx = i;
            end
        end
        checkOutput("b2b_word_count", 64'(words.size()), 64'd2);
        if (words.size() >= 2) begin
            checkOutput("b2b_word0", 64'(words[0]), 64'h04030201);
            checkOutput("b2b_word1", 64'(words[1]), 64'h08070605);
        end
        checkOutput("b2b_first_cycle", 64'(firstIdx), 64'd4);
        checkOutput("b2b_second_cycle", 64'(secondIdx), 64'd8);
        push_valid = 1'b0;

        // Reset in the middle of a partial word.
        applyStimulus(8'h5E, 1'b0);
        applyStimulus(8'h6F, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 64'(pop_valid), 64'd0);
        checkOutput("midrst_data", 64'(pop_data), 64'd0);
        checkOutput("midrst_beats", 64'(pop_beats), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'hA1, 1'b0);
        applyStimulus(8'hA2, 1'b0);
        applyStimulus(8'hA3, 1'b0);
        applyStimulus(8'hA4, 1'b0);
        @(negedge clk);
        checkOutput("midrst_after_valid", 64'(pop_valid), 64'd1);
        checkOutput("midrst_after_data", 64'(pop_data), 64'hA4A3A2A1);
        checkOutput("midrst_after_beats", 64'(pop_beats), 64'd4);
        @(negedge clk);

        // Randomized traffic against the reference model.
        part.delete();
        expQ.delete();
        popped = 0;
        stall  = 1'b0;
        sData  = '0;
        sBeats = '0;
        sLast  = 1'b0;
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            checkOutput("rand_push_ready_rule", 64'(push_ready), 64'(!pop_valid || pop_ready));
            if (stall) begin
                checkOutput("rand_stall_valid", 64'(pop_valid), 64'd1);
                checkOutput("rand_stall_data", 64'(pop_data), 64'(sData));
                checkOutput("rand_stall_beats", 64'(pop_beats), 64'(sBeats));
                checkOutput("rand_stall_last", 64'(pop_last), 64'(sLast));
            end
            if (pop_valid) begin
                checkOutput("rand_beats_range", 64'(pop_beats >= 1 && pop_beats <= NumBeats), 64'd1);
            end
            acc = push_valid && push_ready;
            hs  = pop_valid && pop_ready;
            stall  = pop_valid && !pop_ready;
            sData  = pop_data;
            sBeats = pop_beats;
            sLast  = pop_last;
            if (hs) begin
                if (expQ.size() == 0) begin
                    checkOutput("rand_unexpected_word", 64'(pop_data), 64'hDEAD);
                end else begin
                    w = expQ.pop_front();
                    checkOutput("rand_word_data", 64'(pop_data), 64'(w.data));
                    checkOutput("rand_word_beats", 64'(pop_beats), 64'(w.beats));
                    checkOutput("rand_word_last", 64'(pop_last), 64'(w.last));
                    popped++;
                end
            end
            if (acc) modelBeat(push_data, push_last);
            @(posedge clk);
            #1;
            if (!push_valid || acc) begin
                rd = 8'($urandom);
                rl = ($urandom_range(0, 5) == 0);
                push_valid = ($urandom_range(0, 3) != 0);
                push_data  = rd;
                push_last  = rl;
            end
            pop_ready = ($urandom_range(0, 2) != 0);
        end
        // Let the output drain; anything still pending in the model must
        // come out within a few cycles.
        if (push_valid) begin
            for (int k = 0; k < 20 && push_valid; k++) begin
                pop_ready = 1'b1;
                @(negedge clk);
                acc = push_valid && push_ready;
                hs  = pop_valid && pop_ready;
                if (hs && expQ.size() > 0) begin
                    w = expQ.pop_front();
                    checkOutput("drain_word_data", 64'(pop_data), 64'(w.data));
                    popped++;
                end
                if (acc) modelBeat(push_data, push_last);
                @(posedge clk);
                #1;
                if (acc) push_valid = 1'b0;
            end
        end
        pop_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (pop_valid && expQ.size() > 0) begin
                w = expQ.pop_front();
                checkOutput("drain_word_data", 64'(pop_data), 64'(w.data));
                popped++;
            end
        end
        checkOutput("rand_queue_empty", 64'(expQ.size()), 64'd0);
        checkOutput("rand_words_seen", 64'(popped > 50), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
